// File: rtl/reg_file_decoded.sv
// reg_file_decoded: NUM_REGS x WIDTH register file with one synchronous write port,
// two combinational read ports, GR0 hardwired to zero and a registered one-hot write
// strobe (WSTB) for debug/trace.
// Optional feature: define RF_WRITE_BYPASS_EN to forward PW to a read port whose
// address matches an effective write in the same cycle.
module reg_file_decoded #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 LE,
    input  logic [ADDR_BITS-1:0] RW,
    input  logic [WIDTH-1:0]     PW,
    input  logic [ADDR_BITS-1:0] RA,
    input  logic [ADDR_BITS-1:0] RB,
    output logic [WIDTH-1:0]     PA,
    output logic [WIDTH-1:0]     PB,
    output logic [NUM_REGS-1:0]  WSTB
);

    // GR0 has no storage; only registers 1..NUM_REGS-1 exist.
    logic [WIDTH-1:0]    regs_q  [1:NUM_REGS-1];
    logic [WIDTH-1:0]    rd_val  [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] wstb_q;

    // Enable-gated one-hot write decoder; address 0 and out-of-range addresses decode to zero.
    always_comb begin
        wr_dec = '0;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (LE && (RW == ADDR_BITS'(k))) begin
                wr_dec[k] = 1'b1;
            end
        end
    end

    // Storage and strobe register; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wstb_q <= '0;
        end else begin
            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                if (wr_dec[k]) begin
                    regs_q[k] <= PW;
                end
            end
            wstb_q <= wr_dec;
        end
    end

    // Per-register read value, optionally forwarding the in-flight write data.
    always_comb begin
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            rd_val[k] = regs_q[k];
`ifdef RF_WRITE_BYPASS_EN
            if (!reset && wr_dec[k]) begin
                rd_val[k] = PW;
            end
`endif
        end
    end

    // Read muxes: address 0 and out-of-range addresses match nothing and return zero.
    always_comb begin
        PA = '0;
        PB = '0;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (RA == ADDR_BITS'(k)) begin
                PA = rd_val[k];
            end
            if (RB == ADDR_BITS'(k)) begin
                PB = rd_val[k];
            end
        end
    end

    assign WSTB = wstb_q;

endmodule
